// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined CPU: arbitrates instruction and data
// ports onto one single-ported word RAM with programmable wait states.
module cpu_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_ready,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_ready,
  output logic        stall,
  output logic        align_err,
  output logic        range_err
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    prio_data;
  logic                    lat_data, lat_ren, lat_wen, lat_oor;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [31:0]             lat_wdata;

  logic [31:0] ram [DEPTH];

  logic                  dreq, grant, grant_data, enter_resp;
  logic [31:0]           g_addr, rd_word;
  logic [ADDR_WIDTH-1:0] g_idx, cur_idx;
  logic                  g_oor, cur_data, cur_ren, cur_oor;

  assign dreq       = mem_ren | mem_wen;
  assign grant      = (state == S_IDLE) && (inst_ren || dreq);
  // Contended requests go to the port named by the pointer.
  assign grant_data = dreq && (!inst_ren || prio_data);
  assign g_addr     = grant_data ? mem_addr : inst_addr;
  assign g_idx      = g_addr[ADDR_WIDTH+1:2];
  assign g_oor      = |g_addr[31:ADDR_WIDTH+2];

  assign align_err  = grant && (g_addr[1:0] != 2'b00);
  assign range_err  = grant && g_oor;
  assign stall      = (inst_ren & ~inst_ready) | (dreq & ~mem_ready);

  // With zero wait states the read happens on the grant edge, before the latch fills.
  assign cur_data = (state == S_IDLE) ? grant_data : lat_data;
  assign cur_idx  = (state == S_IDLE) ? g_idx      : lat_idx;
  assign cur_oor  = (state == S_IDLE) ? g_oor      : lat_oor;
  assign cur_ren  = (state == S_IDLE) ? (grant_data ? mem_ren : 1'b1)
                                      : (lat_data   ? lat_ren : 1'b1);
  assign rd_word  = cur_oor ? 32'h0 : ram[cur_idx];

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: if (grant) begin
        if (WAIT_CYCLES == 0) begin
          state_next = S_RESP;
        end else begin
          state_next = S_WAIT;
          cnt_next   = WAIT_INIT;
        end
      end
      S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
              else             cnt_next   = cnt - 4'd1;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign enter_resp = (state_next == S_RESP) && (state != S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      prio_data  <= 1'b1;
      lat_data   <= 1'b0;
      lat_ren    <= 1'b0;
      lat_wen    <= 1'b0;
      lat_oor    <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= 32'h0;
      inst_data  <= 32'h0;
      mem_din    <= 32'h0;
      inst_ready <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      inst_ready <= 1'b0;
      mem_ready  <= 1'b0;
      if (grant) begin
        lat_data  <= grant_data;
        lat_ren   <= grant_data & mem_ren;
        lat_wen   <= grant_data & mem_wen;
        lat_oor   <= g_oor;
        lat_idx   <= g_idx;
        lat_wdata <= mem_dout;
        if (inst_ren && dreq) prio_data <= ~prio_data;
      end
      // Read data is captured entering RESP so it is valid alongside ready.
      if (enter_resp) begin
        if (cur_data) begin
          mem_ready <= 1'b1;
          if (cur_ren) mem_din <= rd_word;
        end else begin
          inst_ready <= 1'b1;
          inst_data  <= rd_word;
        end
      end
    end
  end

  // NOTE: RAM storage has no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (state == S_RESP && lat_data && lat_wen && !lat_oor)
      ram[lat_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder (ADDR_WIDTH=10, WAIT_CYCLES=1).
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_ready;
  logic        stall;
  logic        align_err;
  logic        range_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_ren  (inst_ren),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .inst_ready(inst_ready),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_ready (mem_ready),
    .stall     (stall),
    .align_err (align_err),
    .range_err (range_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at the drive point (1ns after a rising edge); returns at the drive
  // point of the cycle after the ready pulse with requests dropped.
  task automatic access(input bit dport, input bit ren, input bit wen,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat,
                        output logic ae, output logic re);
    bit got;
    rdata = 32'h0; lat = -1; ae = 1'b0; re = 1'b0; got = 1'b0;
    if (dport) begin
      mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata;
    end else begin
      inst_ren = ren; inst_addr = addr;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (n == 0) begin ae = align_err; re = range_err; end
      if (dport ? mem_ready : inst_ready) begin
        got = 1'b1; lat = n; rdata = dport ? mem_din : inst_data;
      end
      @(posedge clk); #1;
    end
    inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] rd;
  int          lat;
  logic        ae, re;
  logic [11:0] mr_seq, ir_seq;

  initial begin
    inst_ren = 0; inst_addr = 0; mem_ren = 0; mem_wen = 0; mem_addr = 0; mem_dout = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_inst_ready", {31'd0, inst_ready}, 0);
    check("rst_mem_ready",  {31'd0, mem_ready},  0);
    check("rst_inst_data",  inst_data, 0);
    check("rst_mem_din",    mem_din,   0);
    do_reset();

    // Preload words 0 and 3 through the data port.
    access(1, 0, 1, 32'h0000_0000, 32'h0BAD_F00D, rd, lat, ae, re);
    check("pre0_lat", lat, 2);
    access(1, 0, 1, 32'h0000_000C, 32'h1234_5678, rd, lat, ae, re);
    check("pre3_lat", lat, 2);

    // Instruction fetch: cycle-exact stall/ready.
    inst_ren = 1'b1; inst_addr = 32'h0000_000C;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("if_stall_c%0d", c), {31'd0, stall}, (c < 2) ? 1 : 0);
      check($sformatf("if_ready_c%0d", c), {31'd0, inst_ready}, (c == 2) ? 1 : 0);
      if (c == 2) check("if_data", inst_data, 32'h1234_5678);
      @(posedge clk); #1;
    end
    inst_ren = 1'b0;

    // Write then read back-to-back.
    access(1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat, ae, re);
    check("wr10_lat", lat, 2);
    access(1, 1, 0, 32'h0000_0010, 32'h0, rd, lat, ae, re);
    check("rd10_lat", lat, 2);
    check("rd10_data", rd, 32'hDEAD_BEEF);

    // ren & wen: write with read-before-write.
    access(1, 1, 1, 32'h0000_0010, 32'h0000_0055, rd, lat, ae, re);
    check("rw10_old", rd, 32'hDEAD_BEEF);
    access(1, 1, 0, 32'h0000_0010, 32'h0, rd, lat, ae, re);
    check("rw10_new", rd, 32'h0000_0055);

    // Out of range read, then dropped write aliasing word 0.
    access(1, 1, 0, 32'h0000_1000, 32'h0, rd, lat, ae, re);
    check("oor_rd_range_err", {31'd0, re}, 1);
    check("oor_rd_align_err", {31'd0, ae}, 0);
    check("oor_rd_data", rd, 32'h0);
    access(1, 0, 1, 32'h0000_1000, 32'hFFFF_FFFF, rd, lat, ae, re);
    check("oor_wr_range_err", {31'd0, re}, 1);
    check("oor_wr_lat", lat, 2);
    access(1, 1, 0, 32'h0000_0000, 32'h0, rd, lat, ae, re);
    check("oor_word0_kept", rd, 32'h0BAD_F00D);
    check("inrange_range_err", {31'd0, re}, 0);

    // Misaligned write lands on word 8.
    access(1, 0, 1, 32'h0000_0022, 32'hA5A5_A5A5, rd, lat, ae, re);
    check("mis_align_err", {31'd0, ae}, 1);
    check("mis_range_err", {31'd0, re}, 0);
    access(1, 1, 0, 32'h0000_0020, 32'h0, rd, lat, ae, re);
    check("mis_readback", rd, 32'hA5A5_A5A5);
    check("al_align_err", {31'd0, ae}, 0);

    // Reset during WAIT aborts a write.
    mem_wen = 1'b1; mem_addr = 32'h0000_0020; mem_dout = 32'h1111_1111;
    @(posedge clk); #1;
    mem_wen = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("abort_mem_din",   mem_din,   0);
    check("abort_inst_data", inst_data, 0);
    check("abort_flags", {27'd0, inst_ready, mem_ready, stall, align_err, range_err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    access(1, 1, 0, 32'h0000_0020, 32'h0, rd, lat, ae, re);
    check("abort_lat", lat, 2);
    check("abort_word_kept", rd, 32'hA5A5_A5A5);

    // Contended arbitration from reset: D, I, D, I.
    do_reset();
    mr_seq = '0; ir_seq = '0;
    inst_ren = 1'b1; inst_addr = 32'h0000_000C;
    mem_ren  = 1'b1; mem_addr  = 32'h0000_0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      mr_seq[c] = mem_ready;
      ir_seq[c] = inst_ready;
      @(posedge clk); #1;
    end
    inst_ren = 1'b0; mem_ren = 1'b0;
    check("arb_mem_seq",  {20'd0, mr_seq}, 32'h104);
    check("arb_inst_seq", {20'd0, ir_seq}, 32'h820);
    check("arb_mem_cnt",  $countones(mr_seq), 2);
    check("arb_inst_cnt", $countones(ir_seq), 2);
    check("arb_inst_data", inst_data, 32'h1234_5678);
    check("arb_mem_din",   mem_din,   32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
